// File: rtl/uart_frame_rx_pkg.sv
// rtl/uart_frame_rx_pkg.sv - byte FSM state encoding and bit-timing helpers
package uart_frame_rx_pkg;

   // Byte receiver states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_STOP    = 3'd3;
   localparam logic [2:0] ST_WAIT_HI = 3'd4;

   localparam int DEF_CLK_HZ = 50_000_000;
   localparam int DEF_BAUD   = 115_200;

   // Clocks per bit-time, truncated
   function automatic int calc_bit_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // Clocks from start-bit edge to start-bit centre
   function automatic int calc_half_div(input int clk_hz, input int baud);
      return calc_bit_div(clk_hz, baud) / 2;
   endfunction

   localparam int DEF_BIT_DIV  = calc_bit_div(DEF_CLK_HZ, DEF_BAUD);
   localparam int DEF_HALF_DIV = calc_half_div(DEF_CLK_HZ, DEF_BAUD);

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - RXD synchroniser, bit timing and 8N1 byte FSM
module uart_rx_byte
   import uart_frame_rx_pkg::*;
#(
   parameter int CLK_HZ = DEF_CLK_HZ,
   parameter int BAUD   = DEF_BAUD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] byte_data,
   output logic       byte_vld,
   output logic       stop_err,
   output logic       busy
);

   localparam int BIT_DIV  = calc_bit_div(CLK_HZ, BAUD);
   localparam int HALF_DIV = calc_half_div(CLK_HZ, BAUD);
   localparam int CNT_W    = $clog2(BIT_DIV + 1);

   logic             sync1;
   logic             rxs;
   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   // Two-flop synchroniser; idle-high line resets to 1 so no false start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   // Byte FSM: centre-sample start, 8 data bits LSB first, then stop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         byte_vld <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         byte_vld <= 1'b0;
         stop_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  state <= ST_START;
                  cnt   <= CNT_W'(HALF_DIV - 1);
               end
            end
            ST_START: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (rxs) begin
                  state <= ST_IDLE;
               end else begin
                  state   <= ST_DATA;
                  cnt     <= CNT_W'(BIT_DIV - 1);
                  bit_idx <= '0;
               end
            end
            ST_DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  shreg   <= {rxs, shreg[7:1]};
                  cnt     <= CNT_W'(BIT_DIV - 1);
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (rxs) begin
                  byte_vld <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  stop_err <= 1'b1;
                  state    <= ST_WAIT_HI;
               end
            end
            ST_WAIT_HI: begin
               if (rxs) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign byte_data = shreg;
   assign busy      = (state != ST_IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - frame assembler, idle flush and channel extraction
module uart_frame_rx
   import uart_frame_rx_pkg::*;
#(
   parameter int CLK_HZ    = DEF_CLK_HZ,
   parameter int BAUD      = DEF_BAUD,
   parameter int N_BYTES   = 16,
   parameter int IDLE_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RXD,
   output logic [39:0] ver_data,
   output logic        ver_valid,
   output logic        frm_err,
   output logic        rx_busy
);

   localparam int BIT_DIV    = calc_bit_div(CLK_HZ, BAUD);
   localparam int IDLE_LIMIT = IDLE_BITS * BIT_DIV;
   localparam int IC_W       = $clog2(IDLE_LIMIT + 1);
   localparam int IDX_W      = $clog2(N_BYTES);

   logic [7:0]       byte_data;
   logic             byte_vld;
   logic             stop_err;
   logic [IDX_W-1:0] index;
   logic [IC_W-1:0]  idle_cnt;
   logic [39:0]      stage;
   logic [39:0]      stage_nxt;
   logic [5:0]       ch_lsb;
   logic             last_byte;
   logic             flush;

   uart_rx_byte #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_byte (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (RXD),
      .byte_data (byte_data),
      .byte_vld  (byte_vld),
      .stop_err  (stop_err),
      .busy      (rx_busy)
   );

   assign ch_lsb    = 6'(index[2:1]) * 6'd10;
   assign last_byte = byte_vld && (index == IDX_W'(N_BYTES - 1));
   assign flush     = !rx_busy && (idle_cnt == IC_W'(IDLE_LIMIT)) && (index != '0);

   // Merge the incoming byte into the packed channel word; even bytes only
   // contribute their top two bits (W[7:6]), odd bytes give W[15:8]
   always_comb begin
      stage_nxt = stage;
      if (byte_vld && (index < IDX_W'(8))) begin
         if (index[0]) begin
            stage_nxt[ch_lsb + 6'd2 +: 8] = byte_data;
         end else begin
            stage_nxt[ch_lsb +: 2] = byte_data[7:6];
         end
      end
   end

   // Byte index: advance on good bytes, restart on stop error or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index <= '0;
      end else if (stop_err || flush) begin
         index <= '0;
      end else if (byte_vld) begin
         index <= last_byte ? '0 : index + IDX_W'(1);
      end
   end

   // Idle timer: counts only while the byte FSM idles, saturates at limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (rx_busy) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IC_W'(IDLE_LIMIT)) begin
         idle_cnt <= idle_cnt + IC_W'(1);
      end
   end

   // Staging word and outputs; ver_data changes only on frame completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage     <= '0;
         ver_data  <= '0;
         ver_valid <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         stage     <= stage_nxt;
         ver_valid <= last_byte;
         frm_err   <= stop_err | flush;
         if (last_byte) begin
            ver_data <= stage_nxt;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx
module tb_uart_frame_rx;

   localparam int BD = 16;

   typedef logic [7:0] frame_t [16];

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        rxd   = 1'b1;
   logic [39:0] ver_data;
   logic        ver_valid;
   logic        frm_err;
   logic        rx_busy;

   int          total    = 0;
   int          bad      = 0;
   int          err_seen = 0;
   int          exp_err  = 0;
   logic [39:0] exp_q[$];
   logic [39:0] mon_exp;

   frame_t fa, fb, fc;
   localparam logic [39:0] EXP_A = 40'hFFF0040155;
   localparam logic [39:0] EXP_B = 40'h3C2AA80001;
   localparam logic [39:0] EXP_C = 40'h800AA557FF;

   always #10 clk = ~clk;

   uart_frame_rx #(
      .CLK_HZ    (50_000_000),
      .BAUD      (3_125_000),
      .N_BYTES   (16),
      .IDLE_BITS (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RXD       (rxd),
      .ver_data  (ver_data),
      .ver_valid (ver_valid),
      .frm_err   (frm_err),
      .rx_busy   (rx_busy)
   );

   // Monitor: pop expected word on every ver_valid, count frm_err pulses
   always @(negedge clk) begin
      if (frm_err) err_seen++;
      if (ver_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid got=%h need=none", ver_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (ver_data !== mon_exp) begin
               bad++;
               $display("FAIL ver_data got=%h need=%h", ver_data, mon_exp);
            end
         end
      end
   end

   task automatic check(input string name, input logic [39:0] got, input logic [39:0] need);
      total++;
      if (got !== need) begin
         bad++;
         $display("FAIL %s got=%h need=%h", name, got, need);
      end
   endtask

   task automatic idle(input int bits);
      repeat (bits * BD) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BD) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (BD) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic send_frame(input frame_t f, input logic [39:0] exp);
      exp_q.push_back(exp);
      for (int i = 0; i < 16; i++) send_byte(f[i], 1'b1);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, 40'(exp_q.size()), 40'd0);
   endtask

   initial begin
      fa = '{8'h40, 8'h55, 8'h00, 8'h40, 8'h00, 8'hC0, 8'hC0, 8'hFF,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      fb = '{8'h7F, 8'h00, 8'h00, 8'h80, 8'h80, 8'hAA, 8'h15, 8'h3C,
             8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
      fc = '{8'hC0, 8'hFF, 8'h40, 8'h55, 8'h80, 8'h2A, 8'h00, 8'h80,
             8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};

      repeat (3) @(negedge clk);
      check("rst_ver_data", ver_data, 40'd0);
      check("rst_ver_valid", 40'(ver_valid), 40'd0);
      check("rst_frm_err", 40'(frm_err), 40'd0);
      check("rst_rx_busy", 40'(rx_busy), 40'd0);
      rst_n = 1'b1;
      idle(2);

      send_frame(fa, EXP_A);
      wait_drain("frame_a_drain");
      idle(3);
      check("frame_a_hold", ver_data, EXP_A);
      check("frame_a_no_err", 40'(err_seen), 40'(exp_err));

      send_frame(fb, EXP_B);
      idle(2);
      check("b2b_hold_b", ver_data, EXP_B);
      send_frame(fc, EXP_C);
      wait_drain("b2b_drain");
      check("b2b_no_err", 40'(err_seen), 40'(exp_err));

      for (int i = 0; i < 5; i++) send_byte(fa[i], 1'b1);
      idle(18);
      check("flush_not_early", 40'(err_seen), 40'(exp_err));
      idle(7);
      exp_err++;
      check("flush_pulse", 40'(err_seen), 40'(exp_err));
      check("flush_hold_c", ver_data, EXP_C);
      send_frame(fa, EXP_A);
      wait_drain("after_flush_drain");

      for (int i = 0; i < 3; i++) send_byte(fb[i], 1'b1);
      send_byte(fb[3], 1'b0);
      rxd = 1'b0;
      repeat (2 * BD) @(negedge clk);
      exp_err++;
      check("stop_err_pulse", 40'(err_seen), 40'(exp_err));
      check("wait_hi_busy", 40'(rx_busy), 40'd1);
      check("stop_err_hold_a", ver_data, EXP_A);
      rxd = 1'b1;
      idle(2);
      check("wait_hi_released", 40'(rx_busy), 40'd0);
      send_frame(fb, EXP_B);
      wait_drain("after_stop_err_drain");

      rxd = 1'b0;
      repeat (5) @(negedge clk);
      rxd = 1'b1;
      repeat (BD) @(negedge clk);
      check("glitch_idle", 40'(rx_busy), 40'd0);
      check("glitch_no_err", 40'(err_seen), 40'(exp_err));
      send_frame(fc, EXP_C);
      wait_drain("after_glitch_drain");

      for (int i = 0; i < 9; i++) send_byte(fa[i], 1'b1);
      rxd = 1'b0;
      repeat (3 * BD) @(negedge clk);
      check("mid_byte_busy", 40'(rx_busy), 40'd1);
      #3 rst_n = 1'b0;
      #1;
      check("areset_ver_data", ver_data, 40'd0);
      check("areset_ver_valid", 40'(ver_valid), 40'd0);
      check("areset_frm_err", 40'(frm_err), 40'd0);
      check("areset_rx_busy", 40'(rx_busy), 40'd0);
      rxd = 1'b1;
      @(negedge clk);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      send_frame(fb, EXP_B);
      wait_drain("after_reset_drain");
      idle(3);
      check("final_hold_b", ver_data, EXP_B);
      check("final_err_count", 40'(err_seen), 40'(exp_err));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
